pe_filter_loader: RTL



---
 rtl/pe_filter_loader_pkg.sv | 18 +
 rtl/pe_filter_loader_if.sv | 27 ++
 rtl/pe_skid_buffer.sv | 52 +++++
 rtl/pe_filter_loader.sv | 111 +++++++++++
 4 files changed

// File: rtl/pe_filter_loader_pkg.sv
// rtl/pe_filter_loader_pkg.sv - shared widths, FSM encoding and skid depth for the filter loader
package pe_filter_loader_pkg;

    localparam int DEFAULT_DATA_WIDTH_FILTER = 64;
    localparam int DEFAULT_ADDR_WIDTH        = 12;
    localparam int DEFAULT_COUNT_WIDTH       = 8;

    // Two entries cover the one-cycle GLB latency plus the word being held
    // against a full FIFO, which is what sustains one word per cycle.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } loader_state_t;

endpackage

// File: rtl/pe_filter_loader_if.sv
// rtl/pe_filter_loader_if.sv - GLB read port and PE filter FIFO write port bundle
// master (loader): drives glb_rd_en, glb_rd_addr, filter, push_filter;
//                  receives glb_rd_data, filter_fifo_full
// slave (GLB/FIFO side): the mirror image
interface pe_filter_loader_if
    import pe_filter_loader_pkg::*;
#(
    parameter int DATA_WIDTH_FILTER = DEFAULT_DATA_WIDTH_FILTER,
    parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH
);
    logic                         glb_rd_en;
    logic [ADDR_WIDTH-1:0]        glb_rd_addr;
    logic [DATA_WIDTH_FILTER-1:0] glb_rd_data;
    logic [DATA_WIDTH_FILTER-1:0] filter;
    logic                         push_filter;
    logic                         filter_fifo_full;

    modport master (
        output glb_rd_en, glb_rd_addr, filter, push_filter,
        input  glb_rd_data, filter_fifo_full
    );

    modport slave (
        input  glb_rd_en, glb_rd_addr, filter, push_filter,
        output glb_rd_data, filter_fifo_full
    );
endinterface

// File: rtl/pe_skid_buffer.sv
// rtl/pe_skid_buffer.sv - 2-entry registered FIFO holding returned GLB words
// clk/reset: clock and synchronous active-high reset
// wr_en/wr_data: push a word; rd_en: pop the head (ignored when empty)
// rd_data: current head; count: number of stored words
module pe_skid_buffer
    import pe_filter_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH_FILTER,
    localparam int CW   = $clog2(SKID_DEPTH + 1),
    localparam int PW   = $clog2(SKID_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_rd;

    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous write and read leaves the occupancy unchanged.
            case ({wr_en, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pe_filter_loader.sv
// rtl/pe_filter_loader.sv - streams a block of filter words from the GLB into the PE filter FIFO
// clk/reset: clock and synchronous active-high reset
// start/base_addr/num_words: transfer request, accepted only while idle
// busy: transfer in progress; done: one-cycle completion pulse
// bus (master): GLB read port (1-cycle latency) and filter FIFO write port
module pe_filter_loader
    import pe_filter_loader_pkg::*;
#(
    parameter int DATA_WIDTH_FILTER = DEFAULT_DATA_WIDTH_FILTER,
    parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
    parameter int COUNT_WIDTH       = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] num_words,
    output logic                   busy,
    output logic                   done,
    pe_filter_loader_if.master     bus
);
    localparam int CW = $clog2(SKID_DEPTH + 1);

    loader_state_t                state;
    loader_state_t                state_nxt;
    logic [ADDR_WIDTH-1:0]        rd_ptr;
    logic [COUNT_WIDTH-1:0]       issue_cnt;
    logic [COUNT_WIDTH-1:0]       push_cnt;
    logic                         inflight;
    logic                         zero_done;
    logic                         issue;
    logic                         pop;
    logic [CW-1:0]                skid_count;
    logic [DATA_WIDTH_FILTER-1:0] skid_head;

    // Reset gates both strobes so an aborted transfer neither pushes nor reads.
    assign pop = (skid_count != '0) && !bus.filter_fifo_full && !reset;

    assign busy            = (state != ST_IDLE);
    assign bus.glb_rd_en   = issue;
    assign bus.glb_rd_addr = rd_ptr;
    assign bus.push_filter = pop;
    assign bus.filter      = skid_head;

    // Returned data lands in the skid buffer unconditionally; the issue credit
    // below keeps buffered + in-flight words within SKID_DEPTH.
    pe_skid_buffer #(
        .WIDTH   (DATA_WIDTH_FILTER)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight),
        .wr_data (bus.glb_rd_data),
        .rd_en   (pop),
        .rd_data (skid_head),
        .count   (skid_count)
    );

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = zero_done;
        unique case (state)
            ST_IDLE: begin
                if (start && (num_words != '0)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A pop this cycle frees a slot, so reads resume the same
                // cycle the FIFO stops back-pressuring.
                issue = (issue_cnt != '0) && !reset &&
                        ((32'(skid_count) + 32'(inflight)) < (SKID_DEPTH + 32'(pop)));
                if (issue && (issue_cnt == COUNT_WIDTH'(1))) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (push_cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            issue_cnt <= '0;
            push_cnt  <= '0;
            inflight  <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            inflight  <= issue;
            zero_done <= (state == ST_IDLE) && start && (num_words == '0);
            if ((state == ST_IDLE) && start) begin
                rd_ptr    <= base_addr;
                issue_cnt <= num_words;
                push_cnt  <= num_words;
            end else begin
                if (issue) begin
                    rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                    issue_cnt <= issue_cnt - COUNT_WIDTH'(1);
                end
                if (pop) begin
                    push_cnt <= push_cnt - COUNT_WIDTH'(1);
                end
            end
        end
    end
endmodule
